// File: rtl/sram_responder_if.sv
// Board-side SRAM bus plus byte-stream preload port for sram_responder.
// The responder takes the slave view; the SoC/bench side takes the master view.
interface sram_responder_if #(
    parameter int unsigned aw = 16
);
    logic          sram_cs_ni;
    logic          sram_wen_ni;
    logic [aw-1:0] sram_addr_i;
    logic [7:0]    sram_data_i;
    logic [7:0]    sram_data_o;
    logic          sram_data_oe_o;
    logic          load_valid_i;
    logic [7:0]    load_data_i;
    logic          load_last_i;
    logic          load_ready_o;

    modport master (
        output sram_cs_ni, sram_wen_ni, sram_addr_i, sram_data_i,
        output load_valid_i, load_data_i, load_last_i,
        input  sram_data_o, sram_data_oe_o, load_ready_o
    );

    modport slave (
        input  sram_cs_ni, sram_wen_ni, sram_addr_i, sram_data_i,
        input  load_valid_i, load_data_i, load_last_i,
        output sram_data_o, sram_data_oe_o, load_ready_o
    );
endinterface

// File: rtl/sram_responder.sv
// Stand-in for the external SRAM: byte array filled by a preload stream while the
// core is held in reset, then served over the bus with saturating access counters.
module sram_responder #(
    parameter int unsigned memsize    = 65536,
    parameter int unsigned aw         = $clog2(memsize),
    parameter bit          PRELOAD_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sram_responder_if.slave    bus,
    output logic               core_rst_no,
    output logic [15:0]        wr_count_o,
    output logic [15:0]        rd_count_o,
    output logic               err_o
);
    typedef enum logic {LOAD, RUN} state_t;

    state_t        state;
    logic [aw-1:0] load_ptr;
    logic [7:0]    mem [memsize];

    logic load_fire;
    logic load_done;
    logic bus_sel;
    logic bus_wr;
    logic bus_rd;
    logic in_range;

    always_comb begin
        load_fire = (state == LOAD) && bus.load_valid_i;
        load_done = load_fire && (bus.load_last_i || (load_ptr == aw'(memsize - 1)));
        bus_sel   = !bus.sram_cs_ni;
        bus_wr    = (state == RUN) && bus_sel && !bus.sram_wen_ni;
        bus_rd    = (state == RUN) && bus_sel &&  bus.sram_wen_ni;
        in_range  = 32'(bus.sram_addr_i) < memsize;
    end

    // Storage is deliberately outside the reset domain so a reset keeps the image.
    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            mem[load_ptr] <= bus.load_data_i;
        end else if (bus_wr && in_range) begin
            mem[bus.sram_addr_i] <= bus.sram_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= PRELOAD_EN ? LOAD : RUN;
            bus.load_ready_o   <= PRELOAD_EN;
            core_rst_no        <= !PRELOAD_EN;
            load_ptr           <= '0;
            bus.sram_data_o    <= '0;
            bus.sram_data_oe_o <= 1'b0;
            wr_count_o         <= '0;
            rd_count_o         <= '0;
            err_o              <= 1'b0;
        end else begin
            bus.sram_data_oe_o <= 1'b0;

            case (state)
                LOAD: begin
                    if (load_fire) begin
                        load_ptr <= load_ptr + aw'(1);
                    end
                    if (load_done) begin
                        state            <= RUN;
                        bus.load_ready_o <= 1'b0;
                        core_rst_no      <= 1'b1;
                    end
                end
                RUN: begin
                end
                default: state <= RUN;
            endcase

            if (bus_rd) begin
                bus.sram_data_o    <= in_range ? mem[bus.sram_addr_i] : '0;
                bus.sram_data_oe_o <= 1'b1;
                if (rd_count_o != '1) begin
                    rd_count_o <= rd_count_o + 16'd1;
                end
            end

            if (bus_wr && (wr_count_o != '1)) begin
                wr_count_o <= wr_count_o + 16'd1;
            end

            if ((bus_sel && (state == LOAD)) || ((bus_rd || bus_wr) && !in_range)) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule
